// File: rtl/ro_test_pkg.sv
// Purpose: shared types and defaults for the ring-oscillator frequency counter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ro_test_pkg;

    localparam int COUNT_W = 32;

    localparam logic [31:0] GATE_CYCLES_DEFAULT = 32'd1_000_000;
    localparam logic [15:0] HOLD_CYCLES_DEFAULT = 16'd128;

    // Measurement sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_GATE  = 3'd2,
        ST_LATCH = 3'd3,
        ST_HOLD  = 3'd4
    } ro_state_t;

    // One full set of measurement results (working or latched).
    typedef struct packed {
        logic [COUNT_W-1:0] inv_cnt;
        logic [COUNT_W-1:0] nand_cnt;
        logic [COUNT_W-1:0] nor_cnt;
        logic [COUNT_W-1:0] clk_cnt;
    } ro_counts_t;

endpackage

// File: rtl/ro_edge_sync.sv
// Purpose: bring an asynchronous RO signal into data_clk and flag its rising edges.
// Latency: rise asserts for one cycle, 3 data_clk edges after the input rises.
// Backpressure: none; one rise pulse per input rising edge.
//
// Ports:
//   data_clk - system clock
//   reset    - synchronous active-high reset, clears all flops
//   ro_in    - asynchronous divided ring-oscillator input
//   rise     - one-cycle pulse per synchronized rising edge
module ro_edge_sync (
    input  logic data_clk,
    input  logic reset,
    input  logic ro_in,
    output logic rise
);

    logic sync1;
    logic sync2;
    logic sync3;

    // sync1/sync2 are the metastability stages; sync3 only delays sync2
    // so the edge detect compares two settled samples.
    always_ff @(posedge data_clk) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= ro_in;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign rise = sync2 & ~sync3;

endmodule

// File: rtl/ro_freq_counter.sv
// Purpose: count RO rising edges and data_clk cycles over a fixed gate window.
// Latency: results and count_valid appear GATE_CYCLES+2 cycles after a window starts.
// Backpressure: none; results are held stable for HOLD_CYCLES after each count_valid.
//
// Ports:
//   data_clk                       - system clock (rising edge)
//   reset                          - synchronous active-high reset
//   enable                         - level request, high = measure continuously
//   inv_ro, nand_ro, nor_ro        - asynchronous divided RO inputs
//   INV/NAND/NOR_COUNT, CLK_COUNT  - latched results of the last completed window
//   count_valid                    - one-cycle pulse when new results are latched
//   busy                           - high whenever the sequencer is not idle
module ro_freq_counter
    import ro_test_pkg::*;
#(
    parameter logic [31:0] GATE_CYCLES = GATE_CYCLES_DEFAULT,
    parameter logic [15:0] HOLD_CYCLES = HOLD_CYCLES_DEFAULT
) (
    input  logic                data_clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                inv_ro,
    input  logic                nand_ro,
    input  logic                nor_ro,
    output logic [COUNT_W-1:0]  INV_COUNT,
    output logic [COUNT_W-1:0]  NAND_COUNT,
    output logic [COUNT_W-1:0]  NOR_COUNT,
    output logic [COUNT_W-1:0]  CLK_COUNT,
    output logic                count_valid,
    output logic                busy
);

    ro_state_t  state;
    ro_state_t  state_nxt;
    ro_counts_t work;
    ro_counts_t result;
    logic [15:0] hold_cnt;

    logic inv_rise;
    logic nand_rise;
    logic nor_rise;
    logic gate_last;
    logic hold_last;

    ro_edge_sync u_inv_sync (
        .data_clk (data_clk),
        .reset    (reset),
        .ro_in    (inv_ro),
        .rise     (inv_rise)
    );

    ro_edge_sync u_nand_sync (
        .data_clk (data_clk),
        .reset    (reset),
        .ro_in    (nand_ro),
        .rise     (nand_rise)
    );

    ro_edge_sync u_nor_sync (
        .data_clk (data_clk),
        .reset    (reset),
        .ro_in    (nor_ro),
        .rise     (nor_rise)
    );

    // The working cycle counter doubles as the gate timer: it has counted
    // GATE_CYCLES-1 cycles at the start of the final gate cycle.
    assign gate_last = (work.clk_cnt == GATE_CYCLES - 32'd1);
    assign hold_last = (hold_cnt == HOLD_CYCLES - 16'd1);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (enable) state_nxt = ST_CLEAR;
            end
            ST_CLEAR: begin
                state_nxt = enable ? ST_GATE : ST_IDLE;
            end
            ST_GATE: begin
                // Losing enable abandons the window, even on its last cycle.
                if (!enable)        state_nxt = ST_IDLE;
                else if (gate_last) state_nxt = ST_LATCH;
            end
            ST_LATCH: begin
                state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                // Results already published always see their hold out.
                if (hold_last) state_nxt = enable ? ST_CLEAR : ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge data_clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            work        <= '0;
            result      <= '0;
            hold_cnt    <= '0;
            count_valid <= 1'b0;
        end else begin
            state       <= state_nxt;
            count_valid <= (state == ST_LATCH);
            case (state)
                ST_CLEAR: begin
                    work <= '0;
                end
                ST_GATE: begin
                    work.inv_cnt  <= work.inv_cnt  + {{(COUNT_W-1){1'b0}}, inv_rise};
                    work.nand_cnt <= work.nand_cnt + {{(COUNT_W-1){1'b0}}, nand_rise};
                    work.nor_cnt  <= work.nor_cnt  + {{(COUNT_W-1){1'b0}}, nor_rise};
                    work.clk_cnt  <= work.clk_cnt  + {{(COUNT_W-1){1'b0}}, 1'b1};
                end
                ST_LATCH: begin
                    result   <= work;
                    hold_cnt <= '0;
                end
                ST_HOLD: begin
                    hold_cnt <= hold_cnt + 16'd1;
                end
                default: begin
                end
            endcase
        end
    end

    assign INV_COUNT  = result.inv_cnt;
    assign NAND_COUNT = result.nand_cnt;
    assign NOR_COUNT  = result.nor_cnt;
    assign CLK_COUNT  = result.clk_cnt;
    assign busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_ro_freq_counter.sv
// Purpose: self-checking bench for ro_freq_counter with a window-position model.
// Latency: n/a.
// Backpressure: n/a.
module tb_ro_freq_counter;

    localparam logic [31:0] G  = 32'd100;
    localparam logic [15:0] H  = 16'd8;
    localparam int          GI = 100;
    localparam int          HI = 8;

    logic        data_clk = 1'b0;
    logic        reset    = 1'b1;
    logic        enable   = 1'b0;
    logic        inv_ro   = 1'b0;
    logic        nand_ro  = 1'b0;
    logic        nor_ro   = 1'b0;
    logic [31:0] INV_COUNT;
    logic [31:0] NAND_COUNT;
    logic [31:0] NOR_COUNT;
    logic [31:0] CLK_COUNT;
    logic        count_valid;
    logic        busy;

    ro_freq_counter #(
        .GATE_CYCLES (G),
        .HOLD_CYCLES (H)
    ) dut (
        .data_clk    (data_clk),
        .reset       (reset),
        .enable      (enable),
        .inv_ro      (inv_ro),
        .nand_ro     (nand_ro),
        .nor_ro      (nor_ro),
        .INV_COUNT   (INV_COUNT),
        .NAND_COUNT  (NAND_COUNT),
        .NOR_COUNT   (NOR_COUNT),
        .CLK_COUNT   (CLK_COUNT),
        .count_valid (count_valid),
        .busy        (busy)
    );

    always #5 data_clk = ~data_clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic check_range(input string name, input logic [31:0] act,
                               input int lo, input int hi);
        n_checks++;
        if (!$isunknown(act) && int'(act) >= lo && int'(act) <= hi) n_pass++;
        else $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    endtask

    // Free-running RO stimulus: inv period 10 clk, nand period 4 clk.
    int inv_ph  = 0;
    int nand_ph = 0;
    always @(negedge data_clk) begin
        inv_ph  = (inv_ph + 1) % 10;
        nand_ph = (nand_ph + 1) % 4;
        inv_ro  = (inv_ph < 5);
        nand_ro = (nand_ph < 2);
    end

    // ---------------- behavioural model ----------------
    // A measurement frame is tracked by its cycle position:
    //   0 = clear, 1..G = gate, G+1 = latch, G+2..G+H+1 = hold.
    // An input rise becomes visible to the window two samples later and is
    // counted if that lands on a gate cycle.
    logic [2:0]  m_inv_h  = '0;
    logic [2:0]  m_nand_h = '0;
    logic [2:0]  m_nor_h  = '0;
    bit          m_active = 1'b0;
    int          m_pos    = 0;
    logic [31:0] m_w_inv = '0, m_w_nand = '0, m_w_nor = '0, m_w_clk = '0;
    logic [31:0] m_inv = '0, m_nand = '0, m_nor = '0, m_clk = '0;
    bit          m_valid = 1'b0;

    always @(posedge data_clk) begin
        bit r_inv;
        bit r_nand;
        bit r_nor;
        r_inv  = m_inv_h[1]  & ~m_inv_h[2];
        r_nand = m_nand_h[1] & ~m_nand_h[2];
        r_nor  = m_nor_h[1]  & ~m_nor_h[2];
        if (reset) begin
            m_active = 1'b0;
            m_valid  = 1'b0;
            m_inv = '0; m_nand = '0; m_nor = '0; m_clk = '0;
            m_w_inv = '0; m_w_nand = '0; m_w_nor = '0; m_w_clk = '0;
            m_inv_h = '0; m_nand_h = '0; m_nor_h = '0;
        end else begin
            m_valid = 1'b0;
            if (!m_active) begin
                if (enable) begin
                    m_active = 1'b1;
                    m_pos    = 0;
                end
            end else if (m_pos == 0) begin
                m_w_inv = '0; m_w_nand = '0; m_w_nor = '0; m_w_clk = '0;
                if (enable) m_pos = 1;
                else        m_active = 1'b0;
            end else if (m_pos <= GI) begin
                m_w_inv  = m_w_inv  + 32'(r_inv);
                m_w_nand = m_w_nand + 32'(r_nand);
                m_w_nor  = m_w_nor  + 32'(r_nor);
                m_w_clk  = m_w_clk  + 32'd1;
                if (!enable) m_active = 1'b0;
                else         m_pos++;
            end else if (m_pos == GI + 1) begin
                m_inv = m_w_inv; m_nand = m_w_nand; m_nor = m_w_nor; m_clk = m_w_clk;
                m_valid = 1'b1;
                m_pos++;
            end else if (m_pos == GI + HI + 1) begin
                if (enable) m_pos = 0;
                else        m_active = 1'b0;
            end else begin
                m_pos++;
            end
            m_inv_h  = {m_inv_h[1:0],  inv_ro};
            m_nand_h = {m_nand_h[1:0], nand_ro};
            m_nor_h  = {m_nor_h[1:0],  nor_ro};
        end
    end

    // Per-cycle comparison of every output against the model.
    bit chk_on = 1'b0;
    always @(negedge data_clk) begin
        if (chk_on) begin
            check("busy",        32'(busy),        32'(m_active));
            check("count_valid", 32'(count_valid), 32'(m_valid));
            check("INV_COUNT",   INV_COUNT,        m_inv);
            check("NAND_COUNT",  NAND_COUNT,       m_nand);
            check("NOR_COUNT",   NOR_COUNT,        m_nor);
            check("CLK_COUNT",   CLK_COUNT,        m_clk);
        end
    end

    // Cycle stamps of count_valid pulses, for interval checks.
    int cyc = 0;
    int vq[$];
    always @(posedge data_clk) cyc++;
    always @(negedge data_clk) if (count_valid === 1'b1) vq.push_back(cyc);

    task automatic wait_valid(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge data_clk);
            if (count_valid === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic count_pulses(input int ncyc, output int pulses);
        pulses = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge data_clk);
            if (count_valid === 1'b1) pulses++;
        end
    endtask

    task automatic run_to_idle();
        enable = 1'b0;
        repeat (HI + 12) @(negedge data_clk);
        check("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        bit seen;
        int pulses;

        // Reset state
        reset = 1'b1;
        repeat (3) @(negedge data_clk);
        chk_on = 1'b1;
        check("rst_busy",  32'(busy),        32'd0);
        check("rst_valid", 32'(count_valid), 32'd0);
        check("rst_inv",   INV_COUNT,        32'd0);
        check("rst_clk",   CLK_COUNT,        32'd0);
        reset = 1'b0;
        repeat (4) @(negedge data_clk);

        // Basic measurement, then enable dropped during HOLD
        enable = 1'b1;
        wait_valid(300, seen);
        check("s1_valid_seen", 32'(seen), 32'd1);
        check("s1_inv",  INV_COUNT,  32'd10);
        check_range("s1_nand", NAND_COUNT, 24, 26);
        check("s1_nor",  NOR_COUNT,  32'd0);
        check("s1_clk",  CLK_COUNT,  32'd100);
        enable = 1'b0;
        repeat (5) @(negedge data_clk);
        check("s6_busy_in_hold", 32'(busy), 32'd1);
        count_pulses(25, pulses);
        check("s6_no_more_pulses", 32'(pulses), 32'd0);
        check("s6_busy_idle", 32'(busy), 32'd0);

        // Free-run for 400 cycles: pulses 110 cycles apart
        vq.delete();
        enable = 1'b1;
        repeat (400) @(negedge data_clk);
        enable = 1'b0;
        #1;
        check("s2_pulse_count", 32'(vq.size()), 32'd3);
        for (int i = 1; i < vq.size(); i++)
            check("s2_interval", 32'(vq[i] - vq[i-1]), 32'd110);
        run_to_idle();

        // Abort at gate cycle 50
        enable = 1'b1;
        repeat (51) @(negedge data_clk);
        enable = 1'b0;
        @(negedge data_clk);
        check("s3_busy_after_abort", 32'(busy), 32'd0);
        check("s3_inv_retained", INV_COUNT, 32'd10);
        check("s3_clk_retained", CLK_COUNT, 32'd100);
        count_pulses(150, pulses);
        check("s3_no_pulse", 32'(pulses), 32'd0);

        // Reset at gate cycle 30, then a fresh measurement
        enable = 1'b1;
        repeat (31) @(negedge data_clk);
        reset = 1'b1;
        @(negedge data_clk);
        reset  = 1'b0;
        enable = 1'b0;
        check("s4_busy",  32'(busy), 32'd0);
        check("s4_inv",   INV_COUNT,  32'd0);
        check("s4_nand",  NAND_COUNT, 32'd0);
        check("s4_clk",   CLK_COUNT,  32'd0);
        repeat (3) @(negedge data_clk);
        enable = 1'b1;
        wait_valid(300, seen);
        check("s4_valid_seen", 32'(seen), 32'd1);
        check("s4_inv_fresh",  INV_COUNT, 32'd10);
        check_range("s4_nand_fresh", NAND_COUNT, 24, 26);
        check("s4_clk_fresh",  CLK_COUNT, 32'd100);
        run_to_idle();

        // Boundary: nor rise whose detect lands on the final gate cycle
        enable = 1'b1;
        repeat (99) @(negedge data_clk);
        nor_ro = 1'b1;
        wait_valid(50, seen);
        check("s5a_valid_seen", 32'(seen), 32'd1);
        check("s5a_nor_last_gate", NOR_COUNT, 32'd1);
        nor_ro = 1'b0;
        run_to_idle();

        // Same edge one cycle later falls on LATCH and is ignored
        enable = 1'b1;
        repeat (100) @(negedge data_clk);
        nor_ro = 1'b1;
        wait_valid(50, seen);
        check("s5b_valid_seen", 32'(seen), 32'd1);
        check("s5b_nor_after_gate", NOR_COUNT, 32'd0);
        nor_ro = 1'b0;
        run_to_idle();

        chk_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ro_freq_counter.md
RO_FREQ_COUNTER -- requirements
Module: ro_freq_counter

Interface
REQ-001 Parameter GATE_CYCLES, default 32'd1_000_000, is the measurement window length in data_clk cycles; the legal range is 1..32'hFFFF_FFFF.
REQ-002 Parameter HOLD_CYCLES, default 16'd128, is the number of cycles results are held stable after each window, matching one full serial output frame.
REQ-003 Port data_clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Port enable, input, 1 bit: level request; high means measure continuously.
REQ-006 Ports inv_ro, nand_ro, nor_ro, input, 1 bit each: divided ring-oscillator outputs, asynchronous to data_clk, with frequency below f(data_clk)/4.
REQ-007 Ports INV_COUNT, NAND_COUNT, NOR_COUNT, output, 32 bits each: latched rising-edge counts of the matching RO input.
REQ-008 Port CLK_COUNT, output, 32 bits: latched number of data_clk cycles in the completed window.
REQ-009 Port count_valid, output, 1 bit: one-cycle pulse marking new results.
REQ-010 Port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-011 Each RO input shall pass through a 2-flop synchronizer followed by a third register; a rising edge is sync2 & ~sync3 (3-cycle latency, one count per edge).
REQ-012 The FSM shall have the states IDLE, CLEAR, GATE, LATCH and HOLD.
- IDLE -> CLEAR when enable=1.
- CLEAR, 1 cycle: zero all working counters, then -> GATE.
- GATE, exactly GATE_CYCLES cycles, then -> LATCH.
- LATCH, 1 cycle, then -> HOLD.
- HOLD, exactly HOLD_CYCLES cycles, then -> CLEAR if enable=1, else IDLE.
REQ-013 In GATE, each working edge counter shall increment by 1 in every cycle its edge detect is high, and the cycle counter shall increment by 1 every cycle.
- An edge in the final GATE cycle counts.
- Edges outside GATE are ignored.
REQ-014 Working counters shall be 32 bits; REQ-006 guarantees no overflow, so no saturation or wrap logic is required.
REQ-015 On the LATCH cycle edge, all four outputs shall load from the working counters simultaneously, and count_valid shall be 1 in the following cycle only.
REQ-016 Outputs shall change only per REQ-015 or reset, so they are stable throughout HOLD, IDLE and the next GATE.
REQ-017 If enable goes low during CLEAR or GATE, the FSM shall go to IDLE on the next edge, discard the partial counts, and leave the outputs unchanged with no count_valid.
REQ-018 If enable goes low during LATCH or HOLD, the current results shall complete normally and the FSM shall then go to IDLE.
REQ-019 In free-run (enable held high), count_valid shall recur every GATE_CYCLES+HOLD_CYCLES+2 cycles.

Reset
REQ-020 While reset=1, on the next data_clk edge: FSM -> IDLE; all working counters, synchronizer flops, INV/NAND/NOR/CLK_COUNT = 0; count_valid = 0; busy = 0.
REQ-021 Reset shall take priority over all other conditions, including a LATCH cycle in progress.

Structure
REQ-022 The state enum, COUNT_W=32 and the default GATE_CYCLES/HOLD_CYCLES shall live in the shared package ro_test_pkg.
REQ-023 Synchronizer plus edge detect shall be the sub-module ro_edge_sync (ports data_clk, reset, ro_in, rise), instantiated three times.

Verification
REQ-024 The bench shall cover the following scenarios, using GATE_CYCLES=100 and HOLD_CYCLES=8.
- Basic measurement: inv_ro period 10 clk, nand_ro period 4, nor_ro held 0, enable pulsed high -> count_valid once; INV=10±1, NAND=25±1, NOR=0, CLK_COUNT=100.
- Free-run: enable held high for 400 cycles -> count_valid pulses exactly 110 cycles apart; outputs constant between pulses.
- Abort: enable dropped at GATE cycle 50 -> IDLE next cycle; no count_valid; outputs retain the previous values (e.g. INV=10).
- Reset mid-GATE: reset=1 for one cycle at GATE cycle 30 -> all outputs 0, busy=0 next cycle; re-enable gives a correct fresh measurement.
- Edge at boundary: a single nor_ro rising edge timed so its detect lands on the final GATE cycle -> NOR=1; the same edge one cycle later -> NOR=0.
- Enable dropped in HOLD: count_valid already seen, FSM -> IDLE after HOLD completes, no further pulse.
